// File: rtl/rsa_pkg.sv
// Shared types for the RSA256 exponentiation controller: state encoding and
// the issue/wait phase flag used by every arithmetic-request state.
package rsa_pkg;

  localparam int BITS_DEFAULT = 256;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_MUL,
    S_SQR,
    S_DONE
  } state_e;

  typedef enum logic {
    PH_ISSUE,
    PH_WAIT
  } phase_e;

endpackage

// File: rtl/rsa_exp_sequencer.sv
// Right-to-left binary exponentiation sequencer in the Montgomery domain.
// Issues one pre-processing request, then drives a shared MP unit one op at a time.
module rsa_exp_sequencer
  import rsa_pkg::*;
#(
  parameter int BITS  = BITS_DEFAULT,
  parameter int CNT_W = $clog2(BITS)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [BITS-1:0] i_a,
  input  logic [BITS-1:0] i_d,
  input  logic [BITS-1:0] i_n,
  output logic            o_prep_start,
  output logic [BITS-1:0] o_prep_a,
  output logic [BITS-1:0] o_prep_n,
  input  logic            i_prep_done,
  input  logic [BITS-1:0] i_prep_result,
  output logic            o_mp_start,
  output logic [BITS-1:0] o_mp_x,
  output logic [BITS-1:0] o_mp_y,
  input  logic            i_mp_done,
  input  logic [BITS-1:0] i_mp_result,
  output logic            o_busy,
  output logic            o_finished,
  output logic [BITS-1:0] o_a_pow_d
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BITS - 1);

  state_e            state_q, state_d;
  phase_e            phase_q, phase_d;
  logic [BITS-1:0]   base_q, base_d;
  logic [BITS-1:0]   exp_q, exp_d;
  logic [BITS-1:0]   mod_q, mod_d;
  logic [BITS-1:0]   t_q, t_d;
  logic [BITS-1:0]   m_q, m_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BITS-1:0]   mp_x_q, mp_x_d;
  logic [BITS-1:0]   mp_y_q, mp_y_d;
  logic [BITS-1:0]   res_q, res_d;

  logic              adv;
  logic [CNT_W-1:0]  adv_idx;
  logic [BITS-1:0]   adv_t;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= S_IDLE;
      phase_q <= PH_ISSUE;
      base_q  <= '0;
      exp_q   <= '0;
      mod_q   <= '0;
      t_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      mp_x_q  <= '0;
      mp_y_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      base_q  <= base_d;
      exp_q   <= exp_d;
      mod_q   <= mod_d;
      t_q     <= t_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      mp_x_q  <= mp_x_d;
      mp_y_q  <= mp_y_d;
      res_q   <= res_d;
    end
  end

  // Done pulses only count in the wait phase; the issue cycle just arms the wait.
  // PREP and SQR both finish through the shared advance step on exponent bit adv_idx.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    base_d  = base_q;
    exp_d   = exp_q;
    mod_d   = mod_q;
    t_d     = t_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    mp_x_d  = mp_x_q;
    mp_y_d  = mp_y_q;
    res_d   = res_q;
    adv     = 1'b0;
    adv_idx = '0;
    adv_t   = t_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          base_d  = i_a;
          exp_d   = i_d;
          mod_d   = i_n;
          m_d     = BITS'(1);
          cnt_d   = '0;
          state_d = S_PREP;
          phase_d = PH_ISSUE;
        end
      end
      S_PREP: begin
        if (phase_q == PH_ISSUE) begin
          phase_d = PH_WAIT;
        end else if (i_prep_done) begin
          t_d   = i_prep_result;
          adv   = 1'b1;
          adv_t = i_prep_result;
        end
      end
      S_MUL: begin
        if (phase_q == PH_ISSUE) begin
          phase_d = PH_WAIT;
        end else if (i_mp_done) begin
          m_d     = i_mp_result;
          phase_d = PH_ISSUE;
          if (cnt_q == LAST_IDX) begin
            state_d = S_DONE;
            res_d   = i_mp_result;
          end else begin
            state_d = S_SQR;
            mp_x_d  = t_q;
            mp_y_d  = t_q;
          end
        end
      end
      S_SQR: begin
        if (phase_q == PH_ISSUE) begin
          phase_d = PH_WAIT;
        end else if (i_mp_done) begin
          t_d     = i_mp_result;
          cnt_d   = cnt_q + CNT_W'(1);
          adv     = 1'b1;
          adv_idx = cnt_q + CNT_W'(1);
          adv_t   = i_mp_result;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The top-bit square is never issued: a clear last bit goes straight to DONE.
    if (adv) begin
      phase_d = PH_ISSUE;
      if (exp_q[adv_idx]) begin
        state_d = S_MUL;
        mp_x_d  = m_q;
        mp_y_d  = adv_t;
      end else if (adv_idx == LAST_IDX) begin
        state_d = S_DONE;
        res_d   = m_q;
      end else begin
        state_d = S_SQR;
        mp_x_d  = adv_t;
        mp_y_d  = adv_t;
      end
    end
  end

  always_comb begin
    o_prep_start = (state_q == S_PREP) && (phase_q == PH_ISSUE);
    o_mp_start   = ((state_q == S_MUL) || (state_q == S_SQR)) && (phase_q == PH_ISSUE);
    o_prep_a     = base_q;
    o_prep_n     = mod_q;
    o_mp_x       = mp_x_q;
    o_mp_y       = mp_y_q;
    o_busy       = (state_q != S_IDLE);
    o_finished   = (state_q == S_DONE);
    o_a_pow_d    = res_q;
  end

endmodule

// File: doc/rsa_exp_sequencer.md
Name: rsa_exp_sequencer

Overview:
Controller that runs 256-bit modular exponentiation a^d mod n for the RSA256 decrypt path, using the right-to-left binary method in the Montgomery domain. It owns no multiplier. It issues one pre-processing request (y·2^BITS mod n) and then drives a single shared Montgomery-product (MP) unit through its start/done handshake, one operation at a time. It sits between the wrapper's key/ciphertext capture logic and the arithmetic units.

Parameters:
BITS, 256, operand/exponent width and Montgomery radix exponent
CNT_W, $clog2(BITS), bit-index counter width

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous, active-low reset
i_start  in  1  request exponentiation; sampled only in IDLE
i_a  in  BITS  base y (ciphertext); captured on accept
i_d  in  BITS  exponent; captured on accept
i_n  in  BITS  odd modulus; captured on accept
o_prep_start  out  1  one-cycle pulse: pre-process captured a with captured n
o_prep_a  out  BITS  captured a (stable while busy)
o_prep_n  out  BITS  captured n (stable while busy)
i_prep_done  in  1  one-cycle pulse, i_prep_result valid
i_prep_result  in  BITS  a·2^BITS mod n
o_mp_start  out  1  one-cycle pulse: compute o_mp_x·o_mp_y·2^-BITS mod n
o_mp_x  out  BITS  MP operand x (stable until matching i_mp_done)
o_mp_y  out  BITS  MP operand y (stable until matching i_mp_done)
i_mp_done  in  1  one-cycle pulse, i_mp_result valid
i_mp_result  in  BITS  MP result
o_busy  out  1  high from accept through the DONE cycle
o_finished  out  1  one-cycle pulse; o_a_pow_d valid
o_a_pow_d  out  BITS  result m; held until next accept

Behaviour:
- Reset (i_rst=0, async): state IDLE. All outputs 0, including o_a_pow_d. Internal t, m, cnt and captured a/d/n cleared. Reset mid-operation aborts immediately; late done pulses arriving after release are ignored.
- States: IDLE, PREP, MUL, SQR, DONE. Each of PREP/MUL/SQR has an issue cycle followed by a wait phase.
- IDLE: on i_start=1, capture a, d, n; set m=1, cnt=0; go to PREP. o_busy rises in the next cycle.
- PREP: o_prep_start=1 in the first PREP cycle only. Wait for i_prep_done, then t←i_prep_result and apply the advance rule with i=0.
- Advance rule for index i: if d[i]=1, go to MUL; else if i=BITS-1, go to DONE; else go to SQR.
- MUL: x=m, y=t, o_mp_start pulses in the first cycle. On i_mp_done, m←result. Then if cnt=BITS-1, go to DONE; else go to SQR.
- SQR: x=t, y=t, pulse as above. On i_mp_done, t←result, cnt←cnt+1, then apply the advance rule with i=cnt+1.
- The final square is never issued. Total MP ops = popcount(d) + (BITS-1), or popcount(d) + index of highest... no: always popcount(d) + (BITS-1) when d[BITS-1]=1; when d[BITS-1]=0, squares still run for i=0..BITS-2, so the total is again popcount(d) + BITS-1.
- DONE: exactly 1 cycle with o_finished=1, o_a_pow_d=m, o_busy=1. Then IDLE.
- Done pulses are honoured only in the wait phase of the matching state. i_prep_done outside PREP-wait and i_mp_done outside MUL/SQR-wait are ignored, as is a done in the issue cycle itself (minimum MP latency is 1 cycle).
- i_start while busy, including the DONE cycle, is ignored. Start in the first IDLE cycle after DONE is accepted.
- Operand outputs are registered and change only on state entry; never while an op is outstanding.
- No arithmetic is done here beyond the counter; cnt wraps never (bounded by BITS-1).

Decomposition:
- Package rsa_pkg: BITS_DEFAULT=256, state enum {S_IDLE,S_PREP,S_MUL,S_SQR,S_DONE}, and an issue/wait phase bit type.
- Flat module; no sub-module is natural. Issue/wait tracking is one flag shared by PREP/MUL/SQR.

Test Plan:
- n=13, a=2, d=3; behavioural prep/MP models with 3-cycle latency -> o_a_pow_d=8 with one o_finished pulse; MP op count 2+255=257, 2 with x=m.
- n=13, a=5, d=0 -> o_a_pow_d=1; 0 MUL and 255 SQR ops; o_prep_start pulses exactly once.
- n=(2^255)+1 (odd), a=7, d=2^255 -> MUL only at i=255 and DONE without a square; result matches reference model; 1 MUL.
- i_start=1 held through a whole run including the DONE cycle -> second run begins the cycle after IDLE is re-entered; captured operands unaffected mid-run by changing i_a/i_d/i_n.
- Spurious i_mp_done during PREP and in the issue cycle, with MP latency varying randomly 1..20 -> pulses ignored; operands stable until the honoured done; result still correct.
- i_rst low during SQR at cnt=100 -> all outputs 0 asynchronously; after release, a stale i_mp_done is ignored; a fresh start with a=2, d=3, n=13 gives 8.
